// File: rtl/adder_bist_pkg.sv
// Shared types and constants for the adder self-test block: FSM encoding,
// operand vector layout, LFSR feedback mask, the four corner vectors and
// the "no error yet" marker.
package adder_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // One operand set as driven onto the adder under test.
    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
    } vec_t;

    // One entry of the golden compare pipeline.
    typedef struct packed {
        logic        vld;
        logic [15:0] idx;
        logic [64:0] sum;   // {cout, sum}
    } gold_t;

    // Galois feedback mask for x^64 + x^63 + x^61 + x^60 + 1 (right shifting).
    localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

    // Corner vectors: full carry ripple, alternating bits with carry-in,
    // maximal operands, and all zero.
    localparam vec_t CORNER_0 = '{a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'h0000_0000_0000_0000, cin: 1'b1};
    localparam vec_t CORNER_1 = '{a: 64'h5555_5555_5555_5555, b: 64'hAAAA_AAAA_AAAA_AAAA, cin: 1'b1};
    localparam vec_t CORNER_2 = '{a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'hFFFF_FFFF_FFFF_FFFF, cin: 1'b1};
    localparam vec_t CORNER_3 = '{a: 64'h0000_0000_0000_0000, b: 64'h0000_0000_0000_0000, cin: 1'b0};

    localparam logic [15:0] ERR_NONE = 16'hFFFF;

    // Next state of the right-shifting Galois LFSR.
    function automatic logic [63:0] lfsr_next(input logic [63:0] s);
        logic [63:0] n;
        n = s >> 1;
        if (s[0]) begin
            n = n ^ LFSR_TAPS;
        end
        return n;
    endfunction

    // Reference result {cout, sum} = a + b + cin, unsigned.
    function automatic logic [64:0] golden_sum(input vec_t v);
        return {1'b0, v.a} + {1'b0, v.b} + {64'd0, v.cin};
    endfunction

endpackage

// File: rtl/lfsr64_galois.sv
// 64-bit Galois LFSR with synchronous seed load and step enable.
// Load has priority over advance.
module lfsr64_galois
    import adder_bist_pkg::*;
#(
    parameter logic [63:0] RESET_SEED = 64'h0000_0000_0000_0001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [63:0] seed,
    input  logic        advance,
    output logic [63:0] state
);

    logic [63:0] state_q;

    // LFSR register: reload on request, otherwise step when told to.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples its inputs from the same edge regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET_SEED;
        end else if (load) begin
            state_q <= seed;
        end else if (advance) begin
            state_q <= lfsr_next(state_q);
        end
    end

    assign state = state_q;

endmodule

// File: rtl/adder_bist.sv
// Self-test stage for the 64-bit adder timing wrapper. Issues four corner
// vectors followed by LFSR vectors, delays a golden sum to line up with the
// adder latency, and accumulates error count, first failing index and pass.
module adder_bist
    import adder_bist_pkg::*;
#(
    parameter int unsigned NUM_VECTORS = 1024,
    parameter int unsigned DUT_LATENCY = 2,
    parameter logic [63:0] SEED_A      = 64'h0123_4567_89AB_CDEF,
    parameter logic [63:0] SEED_B      = 64'hFEDC_BA98_7654_3210
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [63:0] a_out,
    output logic [63:0] b_out,
    output logic        cin_out,
    input  logic [63:0] dut_sum,
    input  logic        dut_cout,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [15:0] first_err_idx
);

    if (NUM_VECTORS < 4 || NUM_VECTORS > 65535) begin : g_bad_num_vectors
        $error("adder_bist: NUM_VECTORS must be within 4..65535");
    end
    if (DUT_LATENCY < 1 || DUT_LATENCY > 8) begin : g_bad_latency
        $error("adder_bist: DUT_LATENCY must be within 1..8");
    end
    if (SEED_A == 64'd0 || SEED_B == 64'd0) begin : g_bad_seed
        $error("adder_bist: LFSR seeds must be nonzero");
    end

    localparam logic [15:0] LAST_IDX   = 16'(NUM_VECTORS - 1);
    localparam logic [3:0]  DRAIN_LAST = 4'(DUT_LATENCY - 1);

    state_e      state_q, state_d;
    logic [15:0] k_q, k_d;          // index of the vector currently on a_out/b_out
    logic [3:0]  drain_q, drain_d;  // cycles spent in DRAIN
    vec_t        vec_q, vec_d;
    logic [15:0] err_q, first_q;

    logic        run_start;
    logic        last_vec;
    logic        lfsr_adv;
    logic [63:0] lfsr_a, lfsr_b;

    gold_t       pipe_q [DUT_LATENCY];
    gold_t       push;
    gold_t       head;
    logic        mismatch;

    // A run begins from IDLE or DONE; start is ignored while busy.
    assign run_start = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign last_vec  = (k_q == LAST_IDX);

    lfsr64_galois #(.RESET_SEED(SEED_A)) u_lfsr_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (run_start),
        .seed    (SEED_A),
        .advance (lfsr_adv),
        .state   (lfsr_a)
    );

    lfsr64_galois #(.RESET_SEED(SEED_B)) u_lfsr_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (run_start),
        .seed    (SEED_B),
        .advance (lfsr_adv),
        .state   (lfsr_b)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: RUN for NUM_VECTORS cycles, DRAIN for DUT_LATENCY cycles.
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE,
            ST_DONE:  if (start)                   state_d = ST_RUN;
            ST_RUN:   if (last_vec)                state_d = ST_DRAIN;
            ST_DRAIN: if (drain_q == DRAIN_LAST)   state_d = ST_DONE;
            default:                               state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: status flags decoded from state; pass needs a clean run.
    always_comb begin
        busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        done = (state_q == ST_DONE);
        pass = (state_q == ST_DONE) && (err_q == 16'd0);
    end

    // Vector issue: the start edge loads vector 0, each RUN cycle loads the
    // next one until the last is on the bus, then the bus holds through DRAIN.
    always_comb begin
        k_d      = k_q;
        vec_d    = vec_q;
        drain_d  = drain_q;
        lfsr_adv = 1'b0;
        if (run_start) begin
            k_d     = 16'd0;
            vec_d   = CORNER_0;
            drain_d = 4'd0;
        end else if (state_q == ST_RUN && !last_vec) begin
            k_d = k_q + 16'd1;
            unique case (k_d)
                16'd1:   vec_d = CORNER_1;
                16'd2:   vec_d = CORNER_2;
                16'd3:   vec_d = CORNER_3;
                default: begin
                    // Random vectors consume the current LFSR state and step it.
                    vec_d    = '{a: lfsr_a, b: lfsr_b, cin: lfsr_a[63] ^ lfsr_b[0]};
                    lfsr_adv = 1'b1;
                end
            endcase
        end else if (state_q == ST_DRAIN) begin
            drain_d = drain_q + 4'd1;
        end
    end

    // Vector, index and drain counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q     <= 16'd0;
            drain_q <= 4'd0;
            vec_q   <= '0;
        end else begin
            k_q     <= k_d;
            drain_q <= drain_d;
            vec_q   <= vec_d;
        end
    end

    assign a_out   = vec_q.a;
    assign b_out   = vec_q.b;
    assign cin_out = vec_q.cin;

    // The golden entry is taken from the registered bus, so its delay through
    // DUT_LATENCY stages matches the adder's delay from a_out to dut_sum.
    assign push = '{vld: (state_q == ST_RUN), idx: k_q, sum: golden_sum(vec_q)};

    // Golden compare pipeline; cleared on reset and at run start.
    // NOTE: this storage is only DUT_LATENCY entries deep, so it is fully
    // reset; that guarantees no stale valid bit can raise a false compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DUT_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else if (run_start) begin
            for (int i = 0; i < DUT_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= push;
            for (int i = 1; i < DUT_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign head     = pipe_q[DUT_LATENCY-1];
    assign mismatch = head.vld && ({dut_cout, dut_sum} != head.sum);

    // Error accounting: saturating count and index of the first mismatch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q   <= 16'd0;
            first_q <= ERR_NONE;
        end else if (run_start) begin
            err_q   <= 16'd0;
            first_q <= ERR_NONE;
        end else if (mismatch) begin
            if (err_q != 16'hFFFF) begin
                err_q <= err_q + 16'd1;
            end
            if (first_q == ERR_NONE) begin
                first_q <= head.idx;
            end
        end
    end

    assign err_count     = err_q;
    assign first_err_idx = first_q;

endmodule

// File: tb/tb_adder_bist.sv
// Directed bench for adder_bist. Two instances, each driving its own
// two-cycle behavioural adder: the main one (latency 2) with an optional
// fault on sum bit 5 for vector 7, and one mis-configured for latency 3.
module tb_adder_bist;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start3;
    logic        fault_en;

    logic [63:0] a_out, b_out, dut_sum;
    logic        cin_out, dut_cout, busy, done, pass;
    logic [15:0] err_count, first_err_idx;

    logic [63:0] a3, b3, sum3;
    logic        cin3, cout3, busy3, done3, pass3;
    logic [15:0] err3, first3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    adder_bist #(.NUM_VECTORS(16), .DUT_LATENCY(2)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .a_out         (a_out),
        .b_out         (b_out),
        .cin_out       (cin_out),
        .dut_sum       (dut_sum),
        .dut_cout      (dut_cout),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_err_idx (first_err_idx)
    );

    adder_bist #(.NUM_VECTORS(16), .DUT_LATENCY(3)) u_dut3 (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start3),
        .a_out         (a3),
        .b_out         (b3),
        .cin_out       (cin3),
        .dut_sum       (sum3),
        .dut_cout      (cout3),
        .busy          (busy3),
        .done          (done3),
        .pass          (pass3),
        .err_count     (err3),
        .first_err_idx (first3)
    );

    // Two-cycle adder model for the main instance; bidx is the busy-cycle
    // number, equal to the index of the vector on a_out during that cycle.
    int          bidx = 0;
    logic [64:0] m_s1 = '0, m_s2 = '0;
    logic        m_t1 = 1'b0, m_t2 = 1'b0;
    always @(posedge clk) begin
        bidx <= busy ? bidx + 1 : 0;
        m_s1 <= {1'b0, a_out} + {1'b0, b_out} + {64'd0, cin_out};
        m_t1 <= fault_en && busy && (bidx == 7);
        m_s2 <= m_s1;
        m_t2 <= m_t1;
    end
    assign dut_sum  = m_s2[63:0] ^ (m_t2 ? 64'h20 : 64'h0);
    assign dut_cout = m_s2[64];

    // Same two-cycle adder for the latency-3 instance.
    logic [64:0] n_s1 = '0, n_s2 = '0;
    always @(posedge clk) begin
        n_s1 <= {1'b0, a3} + {1'b0, b3} + {64'd0, cin3};
        n_s2 <= n_s1;
    end
    assign sum3  = n_s2[63:0];
    assign cout3 = n_s2[64];

    logic [63:0] tr_a [16], tr_b [16], ref_a [16];
    logic        tr_c [16];
    logic [63:0] s2;
    logic        c2, d0, p0;
    logic [15:0] e2;
    int          blen;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pulse start, then record the bus for every busy cycle until busy drops.
    // Optionally pulses start again in busy cycle 5. Returns busy length.
    task automatic run_main(input bit pulse_mid, output int len);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        len = 0;
        while (busy && len < 200) begin
            if (len < 16) begin
                tr_a[len] = a_out;
                tr_b[len] = b_out;
                tr_c[len] = cin_out;
            end
            if (len == 0) begin
                d0 = done;
                p0 = pass;
            end
            if (len == 2) begin
                s2 = dut_sum;
                c2 = dut_cout;
                e2 = err_count;
            end
            start = (pulse_mid && len == 5);
            len++;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " a_out"},         a_out,         64'h0);
        check({tag, " b_out"},         b_out,         64'h0);
        check({tag, " cin_out"},       cin_out,       1'b0);
        check({tag, " busy"},          busy,          1'b0);
        check({tag, " done"},          done,          1'b0);
        check({tag, " pass"},          pass,          1'b0);
        check({tag, " err_count"},     err_count,     16'h0);
        check({tag, " first_err_idx"}, first_err_idx, 16'hFFFF);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        start3   = 1'b0;
        fault_en = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // Clean run against a correct adder.
        run_main(1'b0, blen);
        check("run1 busy_len",  blen,          18);
        check("run1 done",      done,          1'b1);
        check("run1 pass",      pass,          1'b1);
        check("run1 err_count", err_count,     16'h0);
        check("run1 first_idx", first_err_idx, 16'hFFFF);
        check("vec0 a",         tr_a[0],       64'hFFFF_FFFF_FFFF_FFFF);
        check("vec0 b",         tr_b[0],       64'h0);
        check("vec0 cin",       tr_c[0],       1'b1);
        check("vec0 dut_sum",   s2,            64'h0);
        check("vec0 dut_cout",  c2,            1'b1);
        check("vec0 no error",  e2,            16'h0);
        check("vec1 a",         tr_a[1],       64'h5555_5555_5555_5555);
        check("vec1 b",         tr_b[1],       64'hAAAA_AAAA_AAAA_AAAA);
        check("vec2 b",         tr_b[2],       64'hFFFF_FFFF_FFFF_FFFF);
        check("vec3 cin",       tr_c[3],       1'b0);
        // Vector 4 is the raw seeds; cin = A[63] ^ B[0] = 0 ^ 0.
        check("vec4 a",         tr_a[4],       64'h0123_4567_89AB_CDEF);
        check("vec4 b",         tr_b[4],       64'hFEDC_BA98_7654_3210);
        check("vec4 cin",       tr_c[4],       1'b0);
        // One Galois step: A lsb=1 -> (A>>1)^mask; B lsb=0 -> B>>1; cin = 1 ^ 0.
        check("vec5 a",         tr_a[5],       64'hD891_A2B3_C4D5_E6F7);
        check("vec5 b",         tr_b[5],       64'h7F6E_5D4C_3B2A_1908);
        check("vec5 cin",       tr_c[5],       1'b1);
        for (int i = 0; i < 16; i++) ref_a[i] = tr_a[i];

        repeat (3) @(negedge clk);
        check("done held", done, 1'b1);
        check("pass held", pass, 1'b1);

        // Restart from DONE with a stray start in RUN cycle 5.
        run_main(1'b1, blen);
        check("restart done dropped", d0,   1'b0);
        check("restart pass dropped", p0,   1'b0);
        check("restart busy_len",     blen, 18);
        check("restart pass",         pass, 1'b1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("restart a_out[%0d]", i), tr_a[i], ref_a[i]);
        end

        // Fault on sum bit 5 for vector 7 only.
        fault_en = 1'b1;
        run_main(1'b0, blen);
        check("fault err_count", err_count,     16'd1);
        check("fault first_idx", first_err_idx, 16'd7);
        check("fault pass",      pass,          1'b0);
        check("fault done",      done,          1'b1);

        // Reset in the middle of a faulty run after the error was counted.
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (12) @(negedge clk);
        check("midrun err before reset", err_count, 16'd1);
        rst_n = 1'b0;
        #1;
        check_reset_values("midrun reset");
        @(negedge clk);
        rst_n    = 1'b1;
        fault_en = 1'b0;
        run_main(1'b0, blen);
        check("after reset busy_len",  blen,          18);
        check("after reset pass",      pass,          1'b1);
        check("after reset err_count", err_count,     16'h0);
        check("after reset first_idx", first_err_idx, 16'hFFFF);

        // Latency set to 3 against the 2-cycle adder: vector k is compared
        // with the result of vector k+1. Vectors 0 and 1 both give {1, 0},
        // so index 0 matches by coincidence; vector 1 against vector 2's
        // {1, all ones} is the first mismatch.
        @(negedge clk) start3 = 1'b1;
        @(negedge clk) start3 = 1'b0;
        for (int i = 0; i < 100 && !done3; i++) @(negedge clk);
        check("lat3 done",      done3,         1'b1);
        check("lat3 pass",      pass3,         1'b0);
        check("lat3 err nonzero", (err3 != 16'h0), 1'b1);
        check("lat3 first_idx", first3,        16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
